packet_builder: RTL and testbench
=================================

// Module: packet_builder
// PURPOSE
//  Transmit-side counterpart of the packet parser. Takes one five-tuple flow record plus a payload length per transfer.
//  Emits one 256-bit IPv4+UDP header beat toward the MAC TX path, including the IPv4 header checksum.
//  Sits between the flow/scheduler logic (upstream, rx_*) and the MAC TX framer (downstream, tx_*).
// PARAMETERS
//  PACKET_LEN        256  width of tx_data header beat (bits); fixed 256, other values unsupported
//  PACKET_RESULT_LEN 104  width of rx_data five-tuple record (bits) = $bits(five_tuples_t)
//  IP_TTL            64   TTL field value written in every header (8 bits)
//  MAX_PAYLOAD       65507 largest payload_len accepted; larger lengths are dropped
// PORTS
//  clk            in   1    clock; all logic on posedge
//  rst            in   1    reset, synchronous, active-high
//  rx_valid       in   1    upstream record valid
//  rx_data        in   104  five_tuples_t {src_ip[103:72],dst_ip[71:40],src_port[39:24],dst_port[23:8],protocol[7:0]}
//  rx_payload_len in   16   UDP payload bytes for this record; qualified by rx_valid
//  rx_ready       out  1    block can accept a record this cycle
//  tx_valid       out  1    header beat valid
//  tx_data        out  256  header beat; byte 0 at [255:248]
//  tx_ready       in   1    downstream accepts beat
//  drop_cnt       out  16   count of records dropped for oversize length, saturating
// BEHAVIOUR
//  Reset: tx_valid=0, tx_data=0, drop_cnt=0, ID counter=0, all stage valids=0. rx_ready may be 1 during reset, but no transfer counts.
//  Transfers: a record is taken only when rx_valid&rx_ready; a beat is delivered only when tx_valid&tx_ready.
//  Output hold: while tx_valid&!tx_ready, tx_valid and tx_data are held constant.
//  rx_valid/rx_data are never required to depend on rx_ready.
//  Pipeline: 3 register stages S1->S2->S3(output). Latency is 3 cycles from accepting edge to tx_valid, with no stall.
//  Throughput: 1 record/cycle. Stage k loads when it is empty or stage k+1 loads, or k=3 and tx_ready=1.
//  rx_ready = S1 loads. Combinational tx_ready->rx_ready path is permitted. No bubbles are inserted when tx_ready=1.
//  S1: latch tuple; total_len = 28+payload_len (16b); udp_len = 8+payload_len; id = ID counter.
//      Form 20-bit sum of the nonzero IPv4 words.
//  S2: fold the sum twice (end-around carry), then csum = ~fold[15:0].
//  S3: assemble tx_data.
//  Header layout, byte offsets:
//   IPv4: 0 = 0x45; 1 = 0x00; 2-3 = total_len; 4-5 = id; 6-7 = 0x4000 (DF); 8 = IP_TTL; 9 = protocol;
//         10-11 = csum; 12-15 = src_ip; 16-19 = dst_ip.
//   UDP:  20-21 = src_port; 22-23 = dst_port; 24-25 = udp_len; 26-27 = 0x0000 (UDP csum unused).
//   Pad:  28-31 = 0x00.
//  protocol: passed through unchanged; the header is always UDP-shaped regardless of its value.
//  ID counter: +1 per record accepted into S1 that is not dropped; wraps 0xFFFF->0x0000.
//  Oversize drop: payload_len > MAX_PAYLOAD is still accepted (rx_ready semantics unchanged).
//   - S1 does not become valid for it.
//   - The ID counter is not advanced.
//   - drop_cnt +1, saturating at 0xFFFF.
//  Simultaneous events:
//   - Accept into S1 and S2->S3 move on the same cycle are both allowed.
//   - A drop on the same cycle as an S3 output transfer is allowed; the drop does not disturb it.
//  Reset mid-operation: all in-flight records are discarded with no output. The ID counter returns to 0.
// STRUCTURE
//  Shared package packet_parser_types: five_tuples_t (existing); ipv4_hdr_t and udp_hdr_t packed structs;
//  localparams IPV4_VER_IHL=8'h45, IPV4_FLAGS_DF=16'h4000, IPV4_HDR_BYTES=20, UDP_HDR_BYTES=8.
//  Sub-module ipv4_csum_pipe: sum and fold/invert over two stages, with a valid/stall enable shared with the parent.
//  The parent owns the handshake, ID counter, drop logic, and output assembly.
// TESTING
//  1 Single record: src 0x0A000001, dst 0x0A000002, sport 0x1234, dport 0x5678, proto 17, len 100, tx_ready=1.
//    -> tx_valid exactly 3 cycles later; bytes 0-11 = 45 00 0080 0000 4000 40 11 266B;
//       udp_len 0x006C; bytes 28-31 = 0.
//  2 Back-to-back: 8 records with tx_ready=1. -> 8 consecutive tx beats; id 0..7; rx_ready stays 1.
//  3 Backpressure: tx_ready=0 for 10 cycles while rx_valid=1.
//    -> exactly 3 records accepted, then rx_ready=0; tx_data held stable.
//    On release, the next 3 beats arrive in order, with no loss or duplication.
//  4 Oversize: len 65508 between two len-0 records.
//    -> 2 beats out with id 0,1; drop_cnt=1; total_len of the len-0 records = 0x001C.
//  5 Wrap/saturate: preload 65536 records. -> id wraps to 0x0000 on the 65537th.
//    Force 65536 drops. -> drop_cnt holds 0xFFFF.
//  6 Reset mid-flight: assert rst with 3 records in the pipe.
//    -> tx_valid=0 the next cycle; no stale beat after release; first new record has id 0.

Source files
------------

// File: rtl/packet_builder_pkg.sv
// Shared header types and constants for the packet parser / builder pair.
package packet_parser_types;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  protocol;
  } five_tuples_t;

  typedef struct packed {
    logic [7:0]  ver_ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] id;
    logic [15:0] flags_frag;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] csum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ipv4_hdr_t;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] csum;
  } udp_hdr_t;

  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [15:0] IPV4_FLAGS_DF  = 16'h4000;
  localparam int unsigned IPV4_HDR_BYTES = 20;
  localparam int unsigned UDP_HDR_BYTES  = 8;

endpackage

// File: rtl/packet_builder_ipv4_csum_pipe.sv
// Two-stage IPv4 header checksum: word sum on ld1, fold and invert on ld2.
module ipv4_csum_pipe
  import packet_parser_types::*;
#(
  parameter logic [7:0] IP_TTL = 8'd64
) (
  input  logic        clk,
  input  logic        ld1,
  input  logic        ld2,
  input  logic [15:0] total_len,
  input  logic [15:0] id,
  input  logic [7:0]  protocol,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic [15:0] csum
);

  logic [19:0] sum_d;
  logic [19:0] sum_q;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Only the header words that can be nonzero; csum and tos words are zero.
  always_comb begin
    sum_d = 20'({IPV4_VER_IHL, 8'h00}) + 20'(total_len) + 20'(id)
          + 20'(IPV4_FLAGS_DF) + 20'({IP_TTL, protocol})
          + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
          + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
  end

  // Second fold cannot overflow: a carry out of the first leaves fold1[15:0] tiny.
  always_comb begin
    fold1 = 17'(sum_q[15:0]) + 17'(sum_q[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
  end

  always_ff @(posedge clk) begin
    if (ld1) sum_q <= sum_d;
    if (ld2) csum  <= ~fold2;
  end

endmodule

// File: rtl/packet_builder.sv
// Builds one 256-bit IPv4+UDP header beat per five-tuple record, 3-stage pipeline.
module packet_builder
  import packet_parser_types::*;
#(
  parameter int unsigned PACKET_LEN        = 256,
  parameter int unsigned PACKET_RESULT_LEN = 104,
  parameter logic [7:0]  IP_TTL            = 8'd64,
  parameter int unsigned MAX_PAYLOAD       = 65507
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_valid,
  input  logic [PACKET_RESULT_LEN-1:0] rx_data,
  input  logic [15:0]                  rx_payload_len,
  output logic                         rx_ready,
  output logic                         tx_valid,
  output logic [PACKET_LEN-1:0]        tx_data,
  input  logic                         tx_ready,
  output logic [15:0]                  drop_cnt
);

  five_tuples_t rx_tuple, s1_tuple, s2_tuple;
  logic         ld1, ld2, ld3, accept, oversize;
  logic         s1_valid, s2_valid;
  logic [15:0]  rx_total_len, rx_udp_len;
  logic [15:0]  s1_total_len, s1_udp_len, s1_id;
  logic [15:0]  s2_total_len, s2_udp_len, s2_id;
  logic [15:0]  id_cnt, csum;
  ipv4_hdr_t    ip_hdr;
  udp_hdr_t     udp_hdr;

  always_comb begin
    rx_tuple     = five_tuples_t'(rx_data);
    ld3          = !tx_valid || tx_ready;
    ld2          = !s2_valid || ld3;
    ld1          = !s1_valid || ld2;
    rx_ready     = ld1;
    accept       = rx_valid && ld1;
    oversize     = 32'(rx_payload_len) > MAX_PAYLOAD;
    rx_total_len = rx_payload_len + 16'(IPV4_HDR_BYTES + UDP_HDR_BYTES);
    rx_udp_len   = rx_payload_len + 16'(UDP_HDR_BYTES);
  end

  ipv4_csum_pipe #(.IP_TTL(IP_TTL)) u_csum (
    .clk       (clk),
    .ld1       (ld1),
    .ld2       (ld2),
    .total_len (rx_total_len),
    .id        (id_cnt),
    .protocol  (rx_tuple.protocol),
    .src_ip    (rx_tuple.src_ip),
    .dst_ip    (rx_tuple.dst_ip),
    .csum      (csum)
  );

  always_comb begin
    ip_hdr            = '0;
    ip_hdr.ver_ihl    = IPV4_VER_IHL;
    ip_hdr.total_len  = s2_total_len;
    ip_hdr.id         = s2_id;
    ip_hdr.flags_frag = IPV4_FLAGS_DF;
    ip_hdr.ttl        = IP_TTL;
    ip_hdr.protocol   = s2_tuple.protocol;
    ip_hdr.csum       = csum;
    ip_hdr.src_ip     = s2_tuple.src_ip;
    ip_hdr.dst_ip     = s2_tuple.dst_ip;
    udp_hdr           = '0;
    udp_hdr.src_port  = s2_tuple.src_port;
    udp_hdr.dst_port  = s2_tuple.dst_port;
    udp_hdr.length    = s2_udp_len;
  end

  // Dropped records still occupy an accept slot but leave an S1 bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      id_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (ld1) s1_valid <= accept && !oversize;
      if (ld2) s2_valid <= s1_valid;
      if (ld3) tx_valid <= s2_valid;
      if (ld3 && s2_valid) tx_data <= PACKET_LEN'({ip_hdr, udp_hdr, 32'h0});
      if (accept && !oversize) id_cnt <= id_cnt + 16'd1;
      if (accept && oversize && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld1) begin
      s1_tuple     <= rx_tuple;
      s1_total_len <= rx_total_len;
      s1_udp_len   <= rx_udp_len;
      s1_id        <= id_cnt;
    end
    if (ld2) begin
      s2_tuple     <= s1_tuple;
      s2_total_len <= s1_total_len;
      s2_udp_len   <= s1_udp_len;
      s2_id        <= s1_id;
    end
  end

endmodule

// File: tb/tb_packet_builder.sv
// Directed, table-driven bench for packet_builder with hand-computed header values.
module tb_packet_builder;
  import packet_parser_types::*;

  logic         clk = 1'b0;
  logic         rst, rx_valid, rx_ready, tx_valid, tx_ready;
  logic [103:0] rx_data;
  logic [15:0]  rx_payload_len, drop_cnt;
  logic [255:0] tx_data;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [255:0] data;
    int unsigned  cyc;
  } beat_t;
  beat_t beats[$];

  typedef struct {
    logic [31:0] s, d;
    logic [15:0] sp, dp;
    logic [7:0]  pr;
    logic [15:0] len, tl, ul, cs;
  } vec_t;
  vec_t vt[4];

  packet_builder #(
    .PACKET_LEN(256), .PACKET_RESULT_LEN(104), .IP_TTL(8'd64), .MAX_PAYLOAD(65507)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_payload_len(rx_payload_len), .rx_ready(rx_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t nb;
    if (!rst && tx_valid && tx_ready) begin
      nb.data = tx_data;
      nb.cyc  = cyc;
      beats.push_back(nb);
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] s, input logic [31:0] d, input logic [15:0] sp,
                       input logic [15:0] dp, input logic [7:0] pr, input logic [15:0] len);
    rx_valid       = 1'b1;
    rx_data        = {s, d, sp, dp, pr};
    rx_payload_len = len;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    beats.delete();
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 40 && beats.size() < n; i++) @(negedge clk);
    chk("beat_count", 256'(beats.size()), 256'(n));
  endtask

  function automatic logic [255:0] exp_hdr(input logic [31:0] s, input logic [31:0] d,
      input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] pr,
      input logic [15:0] tl, input logic [15:0] id, input logic [15:0] cs, input logic [15:0] ul);
    return {8'h45, 8'h00, tl, id, 16'h4000, 8'h40, pr, cs, s, d, sp, dp, ul, 16'h0000, 32'h0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t        b;
    int unsigned  c0, prev;
    int           k;
    logic [255:0] held;
    bit           held_ok, have;

    vt[0] = '{32'h0A000001, 32'h0A000002, 16'h1234, 16'h5678, 8'h11, 16'd100,
              16'h0080, 16'h006C, 16'h266B};
    vt[1] = '{32'hC0A80001, 32'hC0A800C7, 16'h0035, 16'hD431, 8'h11, 16'd0,
              16'h001C, 16'h0008, 16'hB8B7};
    vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'h0001, 8'h06, 16'd65507,
              16'hFFFF, 16'hFFEB, 16'h3AF7};
    vt[3] = '{32'h01020304, 32'h05060708, 16'h0400, 16'h0050, 8'h11, 16'd1472,
              16'h05DC, 16'h05C8, 16'h24FB};

    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_payload_len = '0; tx_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tx_valid", 256'(tx_valid), 256'(0));
    chk("rst_tx_data", tx_data, 256'(0));
    chk("rst_drop_cnt", 256'(drop_cnt), 256'(0));
    tick();
    rst = 1'b0;

    // single records through the table, ids 0..3
    for (int i = 0; i < 4; i++) begin
      drive(vt[i].s, vt[i].d, vt[i].sp, vt[i].dp, vt[i].pr, vt[i].len);
      c0 = cyc;
      tick();
      rx_valid = 1'b0;
      wait_beats(1);
      if (beats.size() > 0) begin
        b = beats.pop_front();
        chk($sformatf("tbl%0d_data", i), b.data,
            exp_hdr(vt[i].s, vt[i].d, vt[i].sp, vt[i].dp, vt[i].pr, vt[i].tl,
                    16'(i), vt[i].cs, vt[i].ul));
        chk($sformatf("tbl%0d_latency", i), 256'(b.cyc - c0), 256'(3));
      end
      tick();
    end

    // back-to-back
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(32'hAC100000 + 32'(i), 32'hAC10FFFF, 16'(1000 + i), 16'd53, 8'd17, 16'(i * 4));
      @(negedge clk);
      chk("b2b_rx_ready", 256'(rx_ready), 256'(1));
      tick();
    end
    rx_valid = 1'b0;
    wait_beats(8);
    prev = 0;
    for (int i = 0; i < 8 && beats.size() > 0; i++) begin
      b = beats.pop_front();
      chk("b2b_id", 256'(b.data[223:208]), 256'(i));
      chk("b2b_udp_len", 256'(b.data[63:48]), 256'(8 + i * 4));
      if (i > 0) chk("b2b_consecutive", 256'(b.cyc), 256'(prev + 1));
      prev = b.cyc;
    end

    // backpressure
    do_reset();
    tx_ready = 1'b0;
    k = 0; held = '0; held_ok = 1'b1; have = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(32'h0B000000 + 32'(k), 32'h0B0000FF, 16'h0100, 16'h0200, 8'd17, 16'(k));
      @(negedge clk);
      if (tx_valid) begin
        if (!have) begin held = tx_data; have = 1'b1; end
        else if (tx_data !== held) held_ok = 1'b0;
      end
      if (rx_ready) k++;
      tick();
    end
    @(negedge clk);
    chk("bp_accepted", 256'(k), 256'(3));
    chk("bp_rx_ready", 256'(rx_ready), 256'(0));
    chk("bp_tx_valid", 256'(tx_valid), 256'(1));
    chk("bp_hold", 256'(held_ok), 256'(1));
    chk("bp_held_udp_len", 256'(held[63:48]), 256'(8));
    tick();
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    wait_beats(3);
    for (int j = 0; j < 3 && beats.size() > 0; j++) begin
      b = beats.pop_front();
      chk("bp_order_id", 256'(b.data[223:208]), 256'(j));
      chk("bp_order_len", 256'(b.data[63:48]), 256'(8 + j));
    end
    repeat (5) @(negedge clk);
    chk("bp_no_extra", 256'(beats.size()), 256'(0));

    // oversize drop, landing on the same cycle as an output transfer
    do_reset();
    drive(32'h0C000001, 32'h0C000002, 16'h0001, 16'h0002, 8'd17, 16'd0);
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
    drive(32'h0C000003, 32'h0C000004, 16'h0003, 16'h0004, 8'd17, 16'd65508);
    @(negedge clk);
    chk("ovr_rx_ready", 256'(rx_ready), 256'(1));
    chk("ovr_tx_valid_same_cycle", 256'(tx_valid), 256'(1));
    tick();
    drive(32'h0C000005, 32'h0C000006, 16'h0005, 16'h0006, 8'd17, 16'd0);
    tick();
    rx_valid = 1'b0;
    wait_beats(2);
    for (int j = 0; j < 2 && beats.size() > 0; j++) begin
      b = beats.pop_front();
      chk("ovr_id", 256'(b.data[223:208]), 256'(j));
      chk("ovr_total_len", 256'(b.data[239:224]), 256'(16'h001C));
    end
    repeat (3) @(negedge clk);
    chk("ovr_no_extra", 256'(beats.size()), 256'(0));
    chk("ovr_drop_cnt", 256'(drop_cnt), 256'(1));

    // ID wrap and drop saturation, counters preloaded near the top
    do_reset();
    @(negedge clk);
    force dut.id_cnt = 16'hFFFE;
    #1;
    release dut.id_cnt;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0D000000, 32'h0D000001, 16'h0010, 16'h0020, 8'd17, 16'd0);
      tick();
    end
    rx_valid = 1'b0;
    wait_beats(3);
    for (int j = 0; j < 3 && beats.size() > 0; j++) begin
      b = beats.pop_front();
      chk("wrap_id", 256'(b.data[223:208]), 256'(16'(32'hFFFE + j)));
    end
    @(negedge clk);
    force dut.drop_cnt = 16'hFFFD;
    #1;
    release dut.drop_cnt;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0D000000, 32'h0D000001, 16'h0010, 16'h0020, 8'd17, 16'hFFFF);
      tick();
      rx_valid = 1'b0;
      @(negedge clk);
      chk("sat_drop_cnt", 256'(drop_cnt), 256'((i == 0) ? 16'hFFFE : 16'hFFFF));
      tick();
    end
    drive(32'h0D000000, 32'h0D000001, 16'h0010, 16'h0020, 8'd17, 16'd0);
    tick();
    rx_valid = 1'b0;
    wait_beats(1);
    if (beats.size() > 0) begin
      b = beats.pop_front();
      chk("sat_id_not_advanced", 256'(b.data[223:208]), 256'(1));
    end

    // reset with three records in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0E000000 + 32'(i), 32'h0E0000FF, 16'h0001, 16'h0002, 8'd17, 16'(i));
      tick();
    end
    rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_tx_valid", 256'(tx_valid), 256'(0));
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("midrst_no_stale", 256'(beats.size()), 256'(0));
    drive(vt[0].s, vt[0].d, vt[0].sp, vt[0].dp, vt[0].pr, vt[0].len);
    tick();
    rx_valid = 1'b0;
    wait_beats(1);
    if (beats.size() > 0) begin
      b = beats.pop_front();
      chk("midrst_first_beat", b.data,
          exp_hdr(vt[0].s, vt[0].d, vt[0].sp, vt[0].dp, vt[0].pr, vt[0].tl,
                  16'h0000, vt[0].cs, vt[0].ul));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
